b1i_signal_synth: RTL and testbench
===================================

Name: b1i_signal_synth

Overview:
Streaming BeiDou B1I baseband test-signal generator, the transmit-side counterpart of the acquisition chain. Produces 4-bit signed samples at 8 samples/chip (16368 samples per 2046-chip code period). Each sample is a selected PRN's ranging code, offset by a programmable code phase, multiplied by an NCO carrier at a programmable Doppler. It feeds the sample buffer that the acquisition core searches, serving as the bench/loopback stimulus source.

Parameters:
CODE_LENGTH, 2046, chips per code period (G-code truncated from 2047)
SAMPLES_PER_CHIP, 8, samples per chip; 16368 samples per period
NCO_WIDTH, 32, carrier phase accumulator width
MAX_PRN, 37, highest supported PRN

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle request; accepted only in IDLE
prn  in  11  PRN number, valid 1..MAX_PRN
code_phase  in  11  starting chip index, valid 0..2045
doppler_fcw  in  32  NCO frequency control word, added per sample
amp_shift  in  2  arithmetic right-shift applied to the carrier value
num_periods  in  8  code periods to emit; 0 means 256
busy  out  1  high from INIT through DONE
cfg_err  out  1  one-cycle pulse when start is rejected
sample_valid  out  1  sample_data valid
sample_ready  in  1  downstream accepts when valid && ready
sample_data  out  4  signed sample
sample_last  out  1  high with the last sample of each code period
done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy, cfg_err, sample_valid, sample_last, done = 0; sample_data=0; all counters, LFSRs and the NCO cleared. Reset asserted mid-stream aborts immediately, with no done pulse.
- States: IDLE -> INIT -> PRELOAD -> STREAM -> DONE -> IDLE.
- IDLE:
  - start=1 with prn outside 1..MAX_PRN or code_phase>2045: stay in IDLE, pulse cfg_err next cycle.
  - Otherwise latch all configuration inputs and go to INIT.
  - start outside IDLE is ignored; latched configuration is unaffected.
- INIT (1 cycle):
  - G1 = 01010101010; G2 = 01010101010.
  - chip_cnt=0, sub_cnt=0, period_cnt=0, nco=0.
- PRELOAD: steps both LFSRs and chip_cnt once per cycle, code_phase times. code_phase=0 takes 0 cycles, going directly INIT -> STREAM. The last PRELOAD cycle (or INIT) registers the first sample_data.
- STREAM:
  - sample_valid=1.
  - sample_data, sample_last and all state are held while valid && !ready.
  - On each transfer: sub_cnt++; nco += doppler_fcw (mod 2^32); next sample registered.
  - When sub_cnt wraps 7 -> 0: step the LFSRs and increment chip_cnt.
  - When chip_cnt wraps 2045 -> 0: reload both LFSRs to the INIT state.
- Sample formation:
  - chip = G1[11] xor (xor of PRN-selected G2 taps).
  - carrier = COS_LUT[nco[31:29]] >>> amp_shift, with COS_LUT = {7,5,0,-5,-7,-5,0,5}.
  - sample = chip ? -carrier : carrier. Fits in 4 bits with no saturation.
- Code-period boundary:
  - sample_last=1 exactly when the (code period's) sample index is 16367; index counts from the code-period start, independent of code_phase.
  - Periods are counted on sample_last transfers.
  - After num_periods such transfers, go to DONE. sample_valid drops in the same edge.
- DONE (1 cycle): done=1, busy=1. Next cycle IDLE, busy=0.
- Latency: start accepted at edge k; first sample_valid is high in cycle k+2+code_phase.
- LFSRs: G1 polynomial 1+x+x^7+x^8+x^9+x^10+x^11. G2 polynomial 1+x+x^2+x^3+x^4+x^5+x^8+x^9+x^11.

Decomposition:
- Package b1i_pkg holds:
  - CODE_LENGTH, SAMPLES_PER_CHIP
  - G1/G2 initial value and feedback masks
  - the G2 phase-select tap table for PRN 1..37, per the B1I ICD
  - COS_LUT
  - the state enum
- Package b1i_pkg is shared with the acquisition code generator.
- One sub-module, b1i_prn_lfsr: G1/G2 pair with load, step and prn inputs, and a chip output. It is reusable by the receiver code generator.

Test Plan:
1. prn=1, code_phase=0, fcw=0, amp_shift=0, num_periods=1, ready=1:
   - exactly 16368 samples, all ±7, constant within each 8-sample group;
   - sample_last only at index 16367; done one cycle later.
   - Chip sequence bit-matches the golden B1I PRN1 model.
2. Same config with code_phase=5:
   - first sample_valid at k+7;
   - sample n equals sample n+40 of test 1 (mod 16368).
3. fcw=32'h2000_0000, amp_shift=1: carrier per sample is 3,2,0,-3,-4,-3,0,2 repeating, sign flipped per chip.
4. Random sample_ready backpressure, num_periods=2:
   - sample_data and sample_last stable while valid && !ready;
   - 32736 transfers total, identical to the ready=1 run.
5. start with prn=0, then prn=38, then code_phase=2046:
   - cfg_err pulse each time;
   - busy and sample_valid stay 0.
6. rst pulse during STREAM, then start:
   - all outputs 0 the cycle after reset, with no done pulse;
   - the new run restarts from chip 0.

Source files
------------

// File: rtl/b1i_pkg.sv
// Shared B1I definitions: code geometry, LFSR constants, PRN tap table,
// carrier lookup and the generator state encoding.
package b1i_pkg;

    localparam int CODE_LENGTH      = 2046;
    localparam int SAMPLES_PER_CHIP = 8;
    localparam int NCO_WIDTH        = 32;
    localparam int MAX_PRN          = 37;

    // Bit i holds register stage i+1; stage 11 (bit 10) is the output end.
    localparam logic [10:0] G_INIT     = 11'b010_1010_1010;
    // G1: 1+x+x^7+x^8+x^9+x^10+x^11 -> stages 1,7,8,9,10,11 feed back
    localparam logic [10:0] G1_FB_MASK = 11'b111_1100_0001;
    // G2: 1+x+x^2+x^3+x^4+x^5+x^8+x^9+x^11 -> stages 1,2,3,4,5,8,9,11 feed back
    localparam logic [10:0] G2_FB_MASK = 11'b101_1001_1111;

    localparam logic signed [3:0] COS_LUT [8] =
        '{4'sd7, 4'sd5, 4'sd0, -4'sd5, -4'sd7, -4'sd5, 4'sd0, 4'sd5};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_PRELOAD,
        ST_STREAM,
        ST_DONE
    } state_t;

    function automatic logic [10:0] tap_pair(input int a, input int b);
        return (11'd1 << (a - 1)) | (11'd1 << (b - 1));
    endfunction

    // G2 phase-select taps (stage numbers) for each PRN
    function automatic logic [10:0] g2_tap_mask(input logic [10:0] prn);
        case (prn)
            11'd1:  return tap_pair(1, 3);
            11'd2:  return tap_pair(1, 4);
            11'd3:  return tap_pair(1, 5);
            11'd4:  return tap_pair(1, 6);
            11'd5:  return tap_pair(1, 8);
            11'd6:  return tap_pair(1, 9);
            11'd7:  return tap_pair(1, 10);
            11'd8:  return tap_pair(1, 11);
            11'd9:  return tap_pair(2, 7);
            11'd10: return tap_pair(3, 4);
            11'd11: return tap_pair(3, 5);
            11'd12: return tap_pair(3, 6);
            11'd13: return tap_pair(3, 8);
            11'd14: return tap_pair(3, 9);
            11'd15: return tap_pair(3, 10);
            11'd16: return tap_pair(3, 11);
            11'd17: return tap_pair(4, 5);
            11'd18: return tap_pair(4, 6);
            11'd19: return tap_pair(4, 8);
            11'd20: return tap_pair(4, 9);
            11'd21: return tap_pair(4, 10);
            11'd22: return tap_pair(4, 11);
            11'd23: return tap_pair(5, 6);
            11'd24: return tap_pair(5, 8);
            11'd25: return tap_pair(5, 9);
            11'd26: return tap_pair(5, 10);
            11'd27: return tap_pair(5, 11);
            11'd28: return tap_pair(6, 8);
            11'd29: return tap_pair(6, 9);
            11'd30: return tap_pair(6, 10);
            11'd31: return tap_pair(6, 11);
            11'd32: return tap_pair(8, 9);
            11'd33: return tap_pair(8, 10);
            11'd34: return tap_pair(8, 11);
            11'd35: return tap_pair(9, 10);
            11'd36: return tap_pair(9, 11);
            11'd37: return tap_pair(10, 11);
            default: return 11'd0;
        endcase
    endfunction

    // Carrier from the top three NCO bits, scaled, then BPSK-modulated by the chip
    function automatic logic [3:0] form_sample(input logic chip, input logic [2:0] ph,
                                               input logic [1:0] amp);
        logic signed [3:0] carrier;
        carrier = COS_LUT[ph] >>> amp;
        return chip ? -carrier : carrier;
    endfunction

endpackage

// File: rtl/b1i_signal_synth_lfsr.sv
// G1/G2 code generator pair. The chip output reflects the code position the
// registers will hold after this cycle's load/step, so a caller can register
// a sample for that position in the same edge.
module b1i_prn_lfsr
    import b1i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [10:0] prn,
    output logic        chip
);

    logic [10:0] g1;
    logic [10:0] g2;
    logic [10:0] g1_nxt;
    logic [10:0] g2_nxt;
    logic [10:0] tap_mask;

    assign tap_mask = g2_tap_mask(prn);

    // Next register contents: load wins over step
    always_comb begin
        g1_nxt = g1;
        g2_nxt = g2;
        if (load) begin
            g1_nxt = G_INIT;
            g2_nxt = G_INIT;
        end else if (step) begin
            g1_nxt = {g1[9:0], ^(g1 & G1_FB_MASK)};
            g2_nxt = {g2[9:0], ^(g2 & G2_FB_MASK)};
        end
    end

    // Shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            g1 <= '0;
            g2 <= '0;
        end else begin
            g1 <= g1_nxt;
            g2 <= g2_nxt;
        end
    end

    assign chip = g1_nxt[10] ^ (^(g2_nxt & tap_mask));

endmodule

// File: rtl/b1i_signal_synth.sv
// B1I test-signal generator: PRN code at a programmable phase, BPSK onto an
// NCO carrier, streamed out over a valid/ready interface.
//
// state      | meaning
// IDLE       | waiting for start, validates configuration
// INIT       | LFSRs, counters and NCO reset to period start
// PRELOAD    | advancing the code by code_phase chips
// STREAM     | presenting samples, advancing on each transfer
// DONE       | one-cycle completion pulse
module b1i_signal_synth
    import b1i_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [10:0]          prn,
    input  logic [10:0]          code_phase,
    input  logic [NCO_WIDTH-1:0] doppler_fcw,
    input  logic [1:0]           amp_shift,
    input  logic [7:0]           num_periods,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic [3:0]           sample_data,
    output logic                 sample_last,
    output logic                 done
);

    state_t               state;
    logic [10:0]          prn_q;
    logic [10:0]          phase_q;
    logic [NCO_WIDTH-1:0] fcw_q;
    logic [1:0]           amp_q;
    logic [7:0]           num_q;

    logic [10:0]          chip_cnt;
    logic [2:0]           sub_cnt;
    logic [NCO_WIDTH-1:0] nco;
    logic [7:0]           period_cnt;
    logic [10:0]          pre_cnt;

    logic                 cfg_ok;
    logic                 xfer;
    logic                 sub_wrap;
    logic                 chip_wrap;
    logic                 lfsr_load;
    logic                 lfsr_step;
    logic                 code_chip;
    logic [10:0]          chip_cnt_nxt;
    logic [2:0]           sub_nxt;
    logic [NCO_WIDTH-1:0] nco_nxt;
    logic                 last_nxt;
    logic [3:0]           sample_nxt;

    b1i_prn_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .prn  (prn_q),
        .chip (code_chip)
    );

    // Code position, NCO and LFSR controls for the sample to be presented next
    always_comb begin
        cfg_ok    = (prn >= 11'd1) && (prn <= 11'(MAX_PRN)) &&
                    (code_phase <= 11'(CODE_LENGTH - 1));
        xfer      = (state == ST_STREAM) && sample_valid && sample_ready;
        sub_wrap  = (sub_cnt == 3'(SAMPLES_PER_CHIP - 1));
        chip_wrap = (chip_cnt == 11'(CODE_LENGTH - 1));
        lfsr_load = (state == ST_INIT) || (xfer && sub_wrap && chip_wrap);
        lfsr_step = (state == ST_PRELOAD) || (xfer && sub_wrap && !chip_wrap);

        chip_cnt_nxt = chip_cnt;
        sub_nxt      = sub_cnt;
        nco_nxt      = nco;
        case (state)
            ST_INIT: begin
                chip_cnt_nxt = '0;
                sub_nxt      = '0;
                nco_nxt      = '0;
            end
            ST_PRELOAD: chip_cnt_nxt = chip_cnt + 11'd1;
            ST_STREAM: begin
                if (xfer) begin
                    sub_nxt = sub_cnt + 3'd1;
                    nco_nxt = nco + fcw_q;
                    if (sub_wrap)
                        chip_cnt_nxt = chip_wrap ? 11'd0 : chip_cnt + 11'd1;
                end
            end
            default: ;
        endcase

        last_nxt   = (chip_cnt_nxt == 11'(CODE_LENGTH - 1)) &&
                     (sub_nxt == 3'(SAMPLES_PER_CHIP - 1));
        sample_nxt = form_sample(code_chip, nco_nxt[NCO_WIDTH-1 -: 3], amp_q);
    end

    // Sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_last  <= 1'b0;
            done         <= 1'b0;
            prn_q        <= '0;
            phase_q      <= '0;
            fcw_q        <= '0;
            amp_q        <= '0;
            num_q        <= '0;
            chip_cnt     <= '0;
            sub_cnt      <= '0;
            nco          <= '0;
            period_cnt   <= '0;
            pre_cnt      <= '0;
        end else begin
            cfg_err  <= 1'b0;
            done     <= 1'b0;
            chip_cnt <= chip_cnt_nxt;
            sub_cnt  <= sub_nxt;
            nco      <= nco_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            prn_q   <= prn;
                            phase_q <= code_phase;
                            fcw_q   <= doppler_fcw;
                            amp_q   <= amp_shift;
                            num_q   <= num_periods;
                            busy    <= 1'b1;
                            state   <= ST_INIT;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    period_cnt <= '0;
                    pre_cnt    <= phase_q;
                    if (phase_q == 11'd0) begin
                        sample_data  <= sample_nxt;
                        sample_last  <= last_nxt;
                        sample_valid <= 1'b1;
                        state        <= ST_STREAM;
                    end else begin
                        state <= ST_PRELOAD;
                    end
                end
                ST_PRELOAD: begin
                    pre_cnt <= pre_cnt - 11'd1;
                    if (pre_cnt == 11'd1) begin
                        sample_data  <= sample_nxt;
                        sample_last  <= last_nxt;
                        sample_valid <= 1'b1;
                        state        <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        // num_q of zero wraps to 255 here, giving 256 periods
                        if (sample_last && (period_cnt == num_q - 8'd1)) begin
                            sample_valid <= 1'b0;
                            sample_last  <= 1'b0;
                            done         <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            if (sample_last)
                                period_cnt <= period_cnt + 8'd1;
                            sample_data <= sample_nxt;
                            sample_last <= last_nxt;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_b1i_signal_synth.sv
// Bench for b1i_signal_synth: B1I code model built from the stage-wise LFSR
// definition, sample stream predicted from code index and NCO phase.
module tb_b1i_signal_synth;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] prn;
    logic [10:0] code_phase;
    logic [31:0] doppler_fcw;
    logic [1:0]  amp_shift;
    logic [7:0]  num_periods;
    logic        busy;
    logic        cfg_err;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  sample_data;
    logic        sample_last;
    logic        done;

    always #5 clk = ~clk;

    b1i_signal_synth dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .prn          (prn),
        .code_phase   (code_phase),
        .doppler_fcw  (doppler_fcw),
        .amp_shift    (amp_shift),
        .num_periods  (num_periods),
        .busy         (busy),
        .cfg_err      (cfg_err),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .sample_last  (sample_last),
        .done         (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int tap_a [1:37] = '{1,1,1,1,1,1,1,1,2,3,3,3,3,3,3,3,4,4,4,4,4,4,5,5,5,5,5,
                         6,6,6,6,8,8,8,9,9,10};
    int tap_b [1:37] = '{3,4,5,6,8,9,10,11,7,4,5,6,8,9,10,11,5,6,8,9,10,11,6,8,9,
                         10,11,8,9,10,11,9,10,11,10,11,11};
    int lut_model [8] = '{7, 5, 0, -5, -7, -5, 0, 5};
    bit code_tab [2046];

    int          cfg_phase;
    int unsigned cfg_fcw;
    int          cfg_amp;
    int          total;

    task automatic gen_code(input int p);
        bit g1 [12];
        bit g2 [12];
        bit f1;
        bit f2;
        for (int i = 1; i <= 11; i++) begin
            g1[i] = (i % 2 == 0);
            g2[i] = (i % 2 == 0);
        end
        for (int c = 0; c < 2046; c++) begin
            code_tab[c] = g1[11] ^ g2[tap_a[p]] ^ g2[tap_b[p]];
            f1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
            f2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
            for (int i = 11; i >= 2; i--) begin
                g1[i] = g1[i-1];
                g2[i] = g2[i-1];
            end
            g1[1] = f1;
            g2[1] = f2;
        end
    endtask

    function automatic int exp_sample(input int k);
        int          idx;
        int unsigned ph;
        int          car;
        idx = (cfg_phase * 8 + k) % 16368;
        ph  = (k * cfg_fcw) >> 29;
        car = lut_model[ph] >>> cfg_amp;
        return code_tab[idx / 8] ? -car : car;
    endfunction

    function automatic int exp_last(input int k);
        return (((cfg_phase * 8 + k) % 16368) == 16367) ? 1 : 0;
    endfunction

    // ---------------- monitor ----------------
    bit       mon_en = 0;
    bit       rand_ready = 0;
    int       xfer_k;
    bit       done_due;
    bit       stall_prev;
    logic [3:0] held_data;
    logic     held_last;
    int       cap [32736];
    int       t1 [16368];

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                check("hold_data", sample_data, held_data);
                check("hold_last", sample_last, held_last);
            end
            check("done_pulse", done, done_due);
            if (done_due)
                check("valid_after_last", sample_valid, 0);
            done_due = 0;
            if (sample_valid && sample_ready) begin
                if (xfer_k >= total) begin
                    check("extra_transfer", xfer_k, total - 1);
                end else begin
                    check("sample_data", $signed(sample_data), exp_sample(xfer_k));
                    check("sample_last", sample_last, exp_last(xfer_k));
                    if (xfer_k < 32736)
                        cap[xfer_k] = int'($signed(sample_data));
                    if (xfer_k == total - 1)
                        done_due = 1;
                end
                xfer_k++;
            end
            stall_prev = sample_valid && !sample_ready;
            held_data  = sample_data;
            held_last  = sample_last;
        end
    end

    initial begin
        sample_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sample_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- run control ----------------
    task automatic start_run(input int p, input int ph, input int unsigned fcw,
                             input int amp, input int num, input bit rnd);
        int lat;
        cfg_phase  = ph;
        cfg_fcw    = fcw;
        cfg_amp    = amp;
        gen_code(p);
        total      = ((num == 0) ? 256 : num) * 16368 - ph * 8;
        xfer_k     = 0;
        done_due   = 0;
        stall_prev = 0;
        rand_ready = rnd;
        @(negedge clk);
        prn         = 11'(p);
        code_phase  = 11'(ph);
        doppler_fcw = fcw;
        amp_shift   = 2'(amp);
        num_periods = 8'(num);
        start       = 1'b1;
        mon_en      = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!sample_valid && lat < ph + 10);
        check("first_valid_latency", lat, ph + 1);
    endtask

    task automatic finish_run();
        int cyc;
        cyc = 0;
        while (!done && cyc < total * 4 + 100) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
        check("busy_in_done", busy, 1);
        check("transfer_count", xfer_k, total);
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("valid_idle", sample_valid, 0);
        check("done_single", done, 0);
        mon_en     = 0;
        rand_ready = 0;
    endtask

    task automatic bad_start(input int p, input int ph, input string nm);
        @(negedge clk);
        prn        = 11'(p);
        code_phase = 11'(ph);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({nm, "_cfg_err"}, cfg_err, 1);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_valid"}, sample_valid, 0);
        @(posedge clk);
        #1;
        check({nm, "_cfg_err_clear"}, cfg_err, 0);
        check({nm, "_busy_later"}, busy, 0);
        check({nm, "_valid_later"}, sample_valid, 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_cfg_err"}, cfg_err, 0);
        check({nm, "_valid"}, sample_valid, 0);
        check({nm, "_data"}, sample_data, 0);
        check({nm, "_last"}, sample_last, 0);
        check({nm, "_done"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lit3 [8] = '{3, 2, 0, -3, -4, -3, 0, 2};

    initial begin
        int bad;
        int s;
        rst         = 1'b1;
        start       = 1'b0;
        prn         = '0;
        code_phase  = '0;
        doppler_fcw = '0;
        amp_shift   = '0;
        num_periods = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Test 1: PRN1, phase 0, no Doppler, one period
        start_run(1, 0, 32'h0, 0, 1, 0);
        finish_run();
        check("model_chip0", code_tab[0], 0);
        check("model_chip1", code_tab[1], 1);
        check("model_chip2", code_tab[2], 1);
        check("run1_s0", cap[0], 7);
        check("run1_s7", cap[7], 7);
        check("run1_s8", cap[8], -7);
        check("run1_s16", cap[16], -7);
        bad = 0;
        for (int n = 0; n < 16368; n++) begin
            t1[n] = cap[n];
            if ((cap[n] != 7 && cap[n] != -7) || cap[n] != cap[n - (n % 8)])
                bad++;
        end
        check("run1_pm7_grouped", bad, 0);

        // Test 2: code_phase 5 is test 1 shifted by 40 samples
        start_run(1, 5, 32'h0, 0, 1, 0);
        finish_run();
        bad = 0;
        for (int n = 0; n < 16328; n++)
            if (cap[n] != t1[(n + 40) % 16368]) bad++;
        check("phase5_vs_run1", bad, 0);

        // Test 3: carrier stepping one LUT entry per sample, halved amplitude
        start_run(1, 2044, 32'h2000_0000, 1, 1, 0);
        finish_run();
        check("carrier_mag0", (cap[0] < 0) ? -cap[0] : cap[0], 3);
        s = (cap[0] < 0) ? -1 : 1;
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (cap[i] != s * lit3[i]) bad++;
        check("carrier_chip_a", bad, 0);
        s = (cap[8] < 0) ? -1 : 1;
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (cap[8 + i] != s * lit3[i]) bad++;
        check("carrier_chip_b", bad, 0);

        // Test 4: two periods under random backpressure
        start_run(1, 0, 32'h0, 0, 2, 1);
        finish_run();
        bad = 0;
        for (int n = 0; n < 32736; n++)
            if (cap[n] != t1[n % 16368]) bad++;
        check("backpressure_vs_run1", bad, 0);

        // Test 5: rejected configurations
        bad_start(0, 0, "prn0");
        bad_start(38, 0, "prn38");
        bad_start(1, 2046, "phase2046");

        // Test 6: reset mid-stream, then a fresh run from chip 0
        start_run(3, 0, 32'h1234_5678, 0, 1, 0);
        repeat (300) @(negedge clk);
        mon_en = 0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_idle_busy", busy, 0);
        end
        start_run(3, 0, 32'h1234_5678, 0, 1, 0);
        repeat (200) @(negedge clk);
        check("restart_progress", (xfer_k > 150) ? 1 : 0, 1);
        mon_en = 0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
